// File: rtl/sobel_pkg.sv
// Shared constants for the multi-mode Sobel edge stage.
// Mode codes, frame FSM states, direction codes and pipeline depth.
package sobel_pkg;

  localparam logic [1:0] MODE_SUM = 2'd0;
  localparam logic [1:0] MODE_GX  = 2'd1;
  localparam logic [1:0] MODE_GY  = 2'd2;
  localparam logic [1:0] MODE_MAX = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  localparam logic [1:0] DIR_GX   = 2'd0;
  localparam logic [1:0] DIR_DIAG = 2'd1;
  localparam logic [1:0] DIR_GY   = 2'd2;
  localparam logic [1:0] DIR_ANTI = 2'd3;

  localparam int PIPE_LATENCY = 4;

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line pixel store; tap1 is one line up, tap0 two lines up.
// Taps read combinationally, old data read before the write lands.
module sobel_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int AW         = $clog2(IMG_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] tap0,
  output logic [DATA_WIDTH-1:0] tap1
);

  localparam int RW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [AW-1:0] ADDR_LIM = AW'(IMG_WIDTH);

  logic [DATA_WIDTH-1:0] line0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
  logic [RW-1:0]         ra;

  // Out-of-range columns read entry 0; their results are masked anyway.
  always_comb begin
    ra = '0;
    if (addr < ADDR_LIM) ra = addr[RW-1:0];
  end

  assign tap0 = line0[ra];
  assign tap1 = line1[ra];

  // Push the new pixel into line1 and age line1 into line0.
  always_ff @(posedge clk) begin
    if (we) begin
      line1[ra] <= wdata;
      line0[ra] <= line1[ra];
    end
  end

endmodule

// File: rtl/sobel_edge_ms.sv
// Multi-mode streaming Sobel edge detector, 4-cycle pipeline.
// Optional direction output enabled by defining SOBEL_DIR_EN.
module sobel_edge_ms
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] pix_in,
  input  logic                  pix_in_valid,
  input  logic                  pix_in_hsync,
  input  logic                  pix_in_vsync,
  input  logic [DATA_WIDTH+2:0] threshold,
  input  logic [1:0]            mode,
  output logic                  edge_bin,
  output logic [DATA_WIDTH-1:0] edge_mag,
`ifdef SOBEL_DIR_EN
  output logic [1:0]            edge_dir,
`endif
  output logic                  edge_valid,
  output logic                  edge_hsync,
  output logic                  edge_vsync
);

  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int GW = DATA_WIDTH + 3;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH);
  localparam logic [CW-1:0] COL_TWO = CW'(2);
  localparam logic [GW-1:0] PIX_MAX = GW'((1 << DATA_WIDTH) - 1);

  logic                  accept;
  logic                  hs_q;
  logic                  vs_q;
  logic                  hs_fall;
  logic                  vs_rise;
  logic [CW-1:0]         col_q;
  state_e                state_q;
  state_e                state_d;
  logic [1:0]            row_q;
  logic [1:0]            row_d;
  logic [GW-1:0]         thr_q;
  logic [GW-1:0]         thr_d;
  logic [1:0]            mode_q;
  logic [1:0]            mode_d;
  logic                  we;
  logic [DATA_WIDTH-1:0] tap0;
  logic [DATA_WIDTH-1:0] tap1;
  logic [DATA_WIDTH-1:0] win [3][3];
  logic                  pix_mask;
  logic                  acc1, acc2, acc3;
  logic                  msk1, msk2, msk3;
  logic [GW-1:0]         s_l, s_r, s_t, s_b;
  logic signed [GW-1:0]  gx_c, gy_c;
  logic signed [GW-1:0]  gx_q, gy_q;
  logic [GW-1:0]         ax, ay;
  logic [GW-1:0]         mag_c, mag_q;
  logic [PIPE_LATENCY-1:0] vld_sr, hs_sr, vs_sr;

  function automatic logic [GW-1:0] abs_g(
    input logic signed [GW-1:0] v
  );
    logic [GW-1:0] u;
    u = v[GW-1] ? -v : v;
    return u;
  endfunction

  assign accept  = pix_in_valid & pix_in_hsync & pix_in_vsync;
  assign hs_fall = hs_q & ~pix_in_hsync;
  assign vs_rise = ~vs_q & pix_in_vsync;
  assign we      = accept & (col_q < COL_MAX);

  assign pix_mask = (col_q < COL_TWO) | (row_q != 2'd2) |
                    (col_q >= COL_MAX);

  // Sync edge detectors and column counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      col_q <= '0;
    end else begin
      hs_q <= pix_in_hsync;
      vs_q <= pix_in_vsync;
      if (!pix_in_hsync)
        col_q <= '0;
      else if (accept && col_q != COL_MAX)
        col_q <= col_q + 1'b1;
    end
  end

  // Frame FSM register with frame-latched controls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= 2'd0;
      thr_q   <= '0;
      mode_q  <= MODE_SUM;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      thr_q   <= thr_d;
      mode_q  <= mode_d;
    end
  end

  // Frame FSM next state; vsync low wins over a row increment.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    thr_d   = thr_q;
    mode_d  = mode_q;
    if (!pix_in_vsync) begin
      state_d = IDLE;
      row_d   = 2'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          row_d = 2'd0;
          if (vs_rise) begin
            thr_d   = threshold;
            mode_d  = mode;
            state_d = FILL;
          end
        end
        FILL: begin
          if (hs_fall) begin
            row_d = row_q + 2'd1;
            if (row_q == 2'd1) state_d = ACTIVE;
          end
        end
        ACTIVE: row_d = 2'd2;
        default: begin
          state_d = IDLE;
          row_d   = 2'd0;
        end
      endcase
    end
  end

  sobel_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .IMG_WIDTH  (IMG_WIDTH),
    .AW         (CW)
  ) u_lbuf (
    .clk   (clk),
    .we    (we),
    .addr  (col_q),
    .wdata (pix_in),
    .tap0  (tap0),
    .tap1  (tap1)
  );

  // 3x3 window: new column enters on the right on each accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (!pix_in_hsync || !pix_in_vsync) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= tap0;
      win[1][2] <= tap1;
      win[2][2] <= pix_in;
    end
  end

  // Weighted column and row sums, then signed gradients.
  always_comb begin
    s_l = {3'b000, win[0][0]} + {2'b00, win[1][0], 1'b0} +
          {3'b000, win[2][0]};
    s_r = {3'b000, win[0][2]} + {2'b00, win[1][2], 1'b0} +
          {3'b000, win[2][2]};
    s_t = {3'b000, win[0][0]} + {2'b00, win[0][1], 1'b0} +
          {3'b000, win[0][2]};
    s_b = {3'b000, win[2][0]} + {2'b00, win[2][1], 1'b0} +
          {3'b000, win[2][2]};
    gx_c = signed'(s_r - s_l);
    gy_c = signed'(s_t - s_b);
  end

  // Magnitude selection by the frame-latched mode.
  always_comb begin
    ax    = abs_g(gx_q);
    ay    = abs_g(gy_q);
    mag_c = ax + ay;
    unique case (mode_q)
      MODE_SUM: mag_c = ax + ay;
      MODE_GX:  mag_c = ax;
      MODE_GY:  mag_c = ay;
      MODE_MAX: mag_c = (ax > ay) ? ax : ay;
      default:  mag_c = ax + ay;
    endcase
  end

  // Pipeline stages 1-3: accept/mask tags, gradients, magnitude.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc1  <= 1'b0;
      acc2  <= 1'b0;
      acc3  <= 1'b0;
      msk1  <= 1'b1;
      msk2  <= 1'b1;
      msk3  <= 1'b1;
      gx_q  <= '0;
      gy_q  <= '0;
      mag_q <= '0;
    end else begin
      acc1 <= accept;
      acc2 <= acc1;
      acc3 <= acc2;
      if (accept) msk1 <= pix_mask;
      if (acc1) begin
        msk2 <= msk1;
        gx_q <= gx_c;
        gy_q <= gy_c;
      end
      if (acc2) begin
        msk3  <= msk2;
        mag_q <= mag_c;
      end
    end
  end

  // Output stage: threshold, saturate, mask; holds between accepts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_bin <= 1'b1;
      edge_mag <= '0;
    end else if (acc3) begin
      if (msk3) begin
        edge_bin <= 1'b1;
        edge_mag <= '0;
      end else begin
        edge_bin <= ~(mag_q > thr_q);
        edge_mag <= (mag_q > PIX_MAX) ? '1 :
                    mag_q[DATA_WIDTH-1:0];
      end
    end
  end

`ifdef SOBEL_DIR_EN
  logic [1:0]  dir_c;
  logic [1:0]  dir_q;
  logic [GW:0] ax2;
  logic [GW:0] ay2;

  // Direction quantisation from gradient ratio and sign agreement.
  always_comb begin
    ax2   = {ax, 1'b0};
    ay2   = {ay, 1'b0};
    dir_c = (gx_q[GW-1] == gy_q[GW-1]) ? DIR_DIAG : DIR_ANTI;
    if ({1'b0, ax} > ay2)
      dir_c = DIR_GX;
    else if ({1'b0, ay} > ax2)
      dir_c = DIR_GY;
  end

  // Direction register and masked output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q    <= DIR_GX;
      edge_dir <= DIR_GX;
    end else begin
      if (acc2) dir_q <= dir_c;
      if (acc3) edge_dir <= msk3 ? DIR_GX : dir_q;
    end
  end
`endif

  // Sideband delay line, independent of acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_sr <= '0;
      hs_sr  <= '0;
      vs_sr  <= '0;
    end else begin
      vld_sr <= {vld_sr[PIPE_LATENCY-2:0], pix_in_valid};
      hs_sr  <= {hs_sr[PIPE_LATENCY-2:0], pix_in_hsync};
      vs_sr  <= {vs_sr[PIPE_LATENCY-2:0], pix_in_vsync};
    end
  end

  assign edge_valid = vld_sr[PIPE_LATENCY-1];
  assign edge_hsync = hs_sr[PIPE_LATENCY-1];
  assign edge_vsync = vs_sr[PIPE_LATENCY-1];

endmodule

// File: tb/tb_sobel_edge_ms.sv
// Directed bench for sobel_edge_ms at 16-pixel lines.
// Results captured per output pixel and checked against hand values.
module tb_sobel_edge_ms;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam int NR = 8;
  localparam int NC = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] pix_in;
  logic          pix_in_valid;
  logic          pix_in_hsync;
  logic          pix_in_vsync;
  logic [DW+2:0] threshold;
  logic [1:0]    mode;
  logic          edge_bin;
  logic [DW-1:0] edge_mag;
`ifdef SOBEL_DIR_EN
  logic [1:0]    edge_dir;
`endif
  logic          edge_valid;
  logic          edge_hsync;
  logic          edge_vsync;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] img [NR][NC];
  logic          res_bin [NR][NC];
  logic [DW-1:0] res_mag [NR][NC];
  bit            seen [NR][NC];

  bit       sb_chk = 1'b0;
  logic [2:0] hist [4];
  int       orow = 0;
  int       ocol = 0;
  logic     prev_oh = 1'b0;

  sobel_edge_ms #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_in_hsync (pix_in_hsync),
    .pix_in_vsync (pix_in_vsync),
    .threshold    (threshold),
    .mode         (mode),
    .edge_bin     (edge_bin),
    .edge_mag     (edge_mag),
`ifdef SOBEL_DIR_EN
    .edge_dir     (edge_dir),
`endif
    .edge_valid   (edge_valid),
    .edge_hsync   (edge_hsync),
    .edge_vsync   (edge_vsync)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_px(
    input string tag,
    input int    r,
    input int    c,
    input logic  b,
    input int    m
  );
    string t;
    t = $sformatf("%s(%0d,%0d)", tag, r, c);
    chk({t, ".seen"}, 32'(seen[r][c]), 32'd1);
    chk({t, ".bin"}, 32'(res_bin[r][c]), 32'(b));
    chk({t, ".mag"}, 32'(res_mag[r][c]), 32'(m));
  endtask

  // Sideband lag check and per-pixel result capture.
  always @(posedge clk) begin
    hist[3] = hist[2];
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = {pix_in_valid, pix_in_hsync, pix_in_vsync};
    #1;
    if (sb_chk)
      chk("sideband", 32'({edge_valid, edge_hsync, edge_vsync}),
          32'(hist[3]));
    if (!edge_vsync) orow = 0;
    else if (prev_oh && !edge_hsync) orow++;
    if (!edge_hsync) ocol = 0;
    if (edge_valid && edge_hsync && edge_vsync) begin
      if (orow < NR && ocol < NC) begin
        res_bin[orow][ocol] = edge_bin;
        res_mag[orow][ocol] = edge_mag;
        seen[orow][ocol]    = 1'b1;
      end
      ocol++;
    end
    prev_oh = edge_hsync;
  end

  task automatic fill(input int kind);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        unique case (kind)
          0: img[r][c] = (c >= 10) ? 8'd200 : 8'd0;
          1: img[r][c] = 8'd128;
          2: img[r][c] = (c == 0) ? 8'd0 : 8'd250;
          3: img[r][c] = (r >= 4) ? 8'd100 : 8'd0;
          default: img[r][c] = (c >= IW) ? 8'd250 : 8'd50;
        endcase
  endtask

  task automatic drive_line(input int r, input int n);
    for (int c = 0; c < n; c++) begin
      if (c == 5) begin
        pix_in_valid = 1'b0;
        pix_in_hsync = 1'b1;
        @(negedge clk);
      end
      pix_in_hsync = 1'b1;
      pix_in_valid = 1'b1;
      pix_in       = img[r][c];
      @(negedge clk);
    end
    pix_in_valid = 1'b0;
    pix_in_hsync = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drive_frame(
    input int          ncols,
    input logic [1:0]  m,
    input logic [10:0] th,
    input logic [1:0]  m2,
    input logic [10:0] th2
  );
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++)
        seen[r][c] = 1'b0;
    mode      = m;
    threshold = th;
    @(negedge clk);
    pix_in_vsync = 1'b1;
    repeat (2) @(negedge clk);
    for (int r = 0; r < NR; r++) begin
      if (r == 2) begin
        mode      = m2;
        threshold = th2;
      end
      drive_line(r, ncols);
    end
    pix_in_vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) hist[i] = 3'b000;
    reset_n      = 1'b0;
    pix_in       = '0;
    pix_in_valid = 1'b0;
    pix_in_hsync = 1'b0;
    pix_in_vsync = 1'b0;
    threshold    = '0;
    mode         = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_bin", 32'(edge_bin), 32'd1);
    chk("rst_mag", 32'(edge_mag), 32'd0);
    chk("rst_sb", 32'({edge_valid, edge_hsync, edge_vsync}), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    sb_chk = 1'b1;

    // Vertical step: Gx = 800, saturated magnitude.
    fill(0);
    drive_frame(IW, 2'd0, 11'd100, 2'd0, 11'd100);
    chk_px("vstep", 0, 10, 1'b1, 0);
    chk_px("vstep", 1, 10, 1'b1, 0);
    chk_px("vstep", 2, 10, 1'b0, 255);
    chk_px("vstep", 3, 10, 1'b0, 255);
    chk_px("vstep", 4, 11, 1'b0, 255);
    chk_px("vstep", 3, 12, 1'b1, 0);
    chk_px("vstep", 5, 9, 1'b1, 0);
`ifdef SOBEL_DIR_EN
    chk("vstep_dir", 32'(edge_dir), 32'd0);
`endif

    // Flat field with zero threshold.
    fill(1);
    drive_frame(IW, 2'd0, 11'd0, 2'd0, 11'd0);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IW; c++)
        chk_px("flat", r, c, 1'b1, 0);

    // Masked rows/cols against a strong column edge.
    fill(2);
    drive_frame(IW, 2'd0, 11'd100, 2'd0, 11'd100);
    chk_px("mask", 0, 2, 1'b1, 0);
    chk_px("mask", 1, 2, 1'b1, 0);
    chk_px("mask", 5, 0, 1'b1, 0);
    chk_px("mask", 5, 1, 1'b1, 0);
    chk_px("mask", 2, 2, 1'b0, 255);
    chk_px("mask", 5, 2, 1'b0, 255);
    chk_px("mask", 5, 3, 1'b1, 0);

    // Horizontal step, |Gy| = 400; controls change mid-frame.
    fill(3);
    drive_frame(IW, 2'd1, 11'd100, 2'd2, 11'd0);
    chk_px("mode_gx", 4, 8, 1'b1, 0);
    chk_px("mode_gx", 5, 8, 1'b1, 0);
    drive_frame(IW, 2'd2, 11'd100, 2'd1, 11'd2000);
    chk_px("mode_gy", 4, 8, 1'b0, 255);
    chk_px("mode_gy", 5, 8, 1'b0, 255);
    chk_px("mode_gy", 6, 8, 1'b1, 0);
    chk_px("mode_gy", 5, 1, 1'b1, 0);
    drive_frame(IW, 2'd3, 11'd500, 2'd0, 11'd0);
    chk_px("mode_max", 5, 8, 1'b1, 255);
    chk_px("mode_max", 3, 8, 1'b1, 0);

    // Reset in the middle of a line, then a clean frame.
    fill(0);
    mode      = 2'd0;
    threshold = 11'd100;
    pix_in_vsync = 1'b1;
    repeat (2) @(negedge clk);
    for (int r = 0; r < 3; r++) drive_line(r, IW);
    pix_in_hsync = 1'b1;
    for (int c = 0; c < 6; c++) begin
      pix_in_valid = 1'b1;
      pix_in       = img[3][c];
      @(negedge clk);
    end
    sb_chk       = 1'b0;
    reset_n      = 1'b0;
    pix_in_valid = 1'b0;
    pix_in_hsync = 1'b0;
    pix_in_vsync = 1'b0;
    @(posedge clk);
    #2;
    chk("midrst_bin", 32'(edge_bin), 32'd1);
    chk("midrst_mag", 32'(edge_mag), 32'd0);
    chk("midrst_sb",
        32'({edge_valid, edge_hsync, edge_vsync}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    sb_chk = 1'b1;
    fill(1);
    drive_frame(IW, 2'd0, 11'd0, 2'd0, 11'd0);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < IW; c++)
        chk_px("recover", r, c, 1'b1, 0);

    // Over-length line: extra pixels masked, buffer untouched.
    fill(4);
    drive_frame(NC, 2'd0, 11'd100, 2'd0, 11'd100);
    for (int c = IW; c < NC; c++)
      chk_px("overlen", 4, c, 1'b1, 0);
    chk_px("overlen", 4, 3, 1'b1, 0);
    chk_px("overlen", 4, 4, 1'b1, 0);
    chk_px("overlen", 4, 5, 1'b1, 0);
    chk_px("overlen", 5, 15, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
